ob_mk_cnt_sched: RTL and testbench
==================================

Name: ob_mk_cnt_sched

Overview:
- Round-robin scheduler that shares one market-order table-count engine between REQ_N requesters (e.g. bid/ask book sides).
- Accepts one count request, drives the engine's table-select mux and its single-cycle command, and tracks engine busy.
- Captures the accumulated quantity and returns it, tagged with the requester id, over a valid/ready response channel.
- Watchdog reports an error if the engine stalls.

Parameters:
- REQ_N, 2, number of requesters (>=2).
- ACC_W, 32, accumulated quantity width; equals $bits(ob_pkg::accum_quantity_t).
- TIMEOUT_N, 64, maximum cycles spent in BUSY before the watchdog fires (>=8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  REQ_N  per-requester count request.
- req_rdy  out  REQ_N  one-hot grant; acceptance when req_vld[i] & req_rdy[i].
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumed.
- rsp_id  out  $clog2(REQ_N)  requester id of the response.
- rsp_quantity  out  ACC_W  accumulated quantity.
- rsp_err  out  1  response is a watchdog or protocol error; quantity is 0.
- cnt_cmd_vld  out  1  engine command strobe.
- cnt_tbl_sel  out  $clog2(REQ_N)  selects which requester's table drives the engine.
- cnt_busy  in  1  engine next-state busy flag, combinational from the engine.
- cnt_rsp_quantity  in  ACC_W  engine result; valid in the cycle cnt_busy falls.

Behaviour:
- Single clock. Reset is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - Outputs 0: req_rdy, rsp_vld, rsp_id, rsp_quantity, rsp_err, cnt_cmd_vld, cnt_tbl_sel.
  - rr_ptr = REQ_N-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, BUSY, RSP. Encoding is free.
- IDLE:
  - Select the first requester with req_vld set, searching from rr_ptr+1 modulo REQ_N.
  - Assert that requester's req_rdy bit combinationally; req_rdy is 0 in all other states.
  - On acceptance: register grant id into cnt_tbl_sel and rsp_id, set rr_ptr = grant, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - cnt_cmd_vld = 1.
  - cnt_busy must be 1 this cycle. If so, go to BUSY and clear the watchdog counter.
  - If cnt_busy = 0 (engine refused): rsp_err = 1, rsp_quantity = 0, go to RSP.
- BUSY:
  - Watchdog counter increments each cycle.
  - If cnt_busy = 0: register cnt_rsp_quantity into rsp_quantity, rsp_err = 0, go to RSP.
  - Else if counter == TIMEOUT_N-1: rsp_err = 1, rsp_quantity = 0, go to RSP.
  - The engine is not reset on timeout; the next ISSUE detects a still-busy engine via the ISSUE rule.
- RSP:
  - rsp_vld = 1; rsp_id, rsp_quantity and rsp_err are held stable.
  - On rsp_rdy, go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- cnt_tbl_sel is held constant from acceptance through the capture cycle, so the engine's table input is stable across all accumulation rounds.
- Latency:
  - Acceptance at cycle 0, cnt_cmd_vld at cycle 1.
  - Engine with N entries, MUX_IN_N = ceil(N/6): capture at cycle MUX_IN_N+3, rsp_vld at cycle MUX_IN_N+4.
  - N=16 gives rsp_vld at cycle 7.
- No arithmetic is performed on the result: ACC_W is passed through unmodified, and overflow is owned by the engine.
- Requests arriving while not in IDLE are not accepted; requesters hold req_vld until granted.
- rr_ptr advances only on acceptance, never on an idle cycle.
- Reset asserted mid-operation: immediate return to reset values. Any pending response is lost, and cnt_cmd_vld drops asynchronously.

Test Plan:
- Single request: req_vld=01, engine N=16 returning 0x1234 → req_rdy=01 at cycle 0, cnt_cmd_vld at cycle 1 only, rsp_vld at cycle 7 with rsp_id=0, rsp_quantity=0x1234, rsp_err=0.
- Fairness: req_vld=11 held, rsp_rdy=1 → grants alternate 0,1,0,1 over four responses; cnt_tbl_sel matches rsp_id each time.
- Backpressure: rsp_rdy=0 for 10 cycles after rsp_vld → outputs stable, no req_rdy asserted, no cnt_cmd_vld; accept on rsp_rdy, next grant the following cycle.
- Watchdog: engine model holds cnt_busy=1 forever, TIMEOUT_N=64 → rsp_vld with rsp_err=1, rsp_quantity=0 exactly 64 cycles after entering BUSY.
- Engine refusal: cnt_busy=0 during ISSUE → rsp_err=1 at the next cycle, rsp_id = granted id.
- Async reset: drop rst_n mid-BUSY, off-edge → all outputs 0 immediately; after release, req_vld=10 is granted to requester 0 only if req_vld[0]=1, otherwise to requester 1.

Source files
------------

// File: rtl/ob_mk_cnt_sched.sv
// Round-robin scheduler that shares one market-order table-count engine
// between REQ_N requesters. One request is granted at a time: the engine is
// pointed at the winner's table, given a single-cycle command, watched until
// it goes idle (or stalls), and the captured quantity is returned tagged with
// the requester id over a valid/ready response channel.
module ob_mk_cnt_sched #(
    parameter int REQ_N     = 2,
    parameter int ACC_W     = 32,
    parameter int TIMEOUT_N = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_N-1:0]           req_vld,
    output logic [REQ_N-1:0]           req_rdy,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [$clog2(REQ_N)-1:0]   rsp_id,
    output logic [ACC_W-1:0]           rsp_quantity,
    output logic                       rsp_err,
    output logic                       cnt_cmd_vld,
    output logic [$clog2(REQ_N)-1:0]   cnt_tbl_sel,
    input  logic                       cnt_busy,
    input  logic [ACC_W-1:0]           cnt_rsp_quantity
);

    localparam int ID_W = $clog2(REQ_N);
    localparam int WD_W = $clog2(TIMEOUT_N);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RSP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic [WD_W-1:0] wd_cnt;

    // Pick the first requesting index after the last winner, wrapping around.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx         = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= REQ_N; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % REQ_N);
            if (!grant_found && req_vld[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // The grant is offered only while idle, so at most one request is in flight.
    always_comb begin
        req_rdy = '0;
        if (state == IDLE && grant_found) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    // Request/issue/wait/respond sequencer with registered engine and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(REQ_N - 1);
            wd_cnt       <= '0;
            rsp_vld      <= 1'b0;
            rsp_id       <= '0;
            rsp_quantity <= '0;
            rsp_err      <= 1'b0;
            cnt_cmd_vld  <= 1'b0;
            cnt_tbl_sel  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr      <= grant_id;
                        rsp_id      <= grant_id;
                        cnt_tbl_sel <= grant_id;
                        cnt_cmd_vld <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_cmd_vld <= 1'b0;
                    if (cnt_busy) begin
                        wd_cnt <= '0;
                        state  <= BUSY;
                    end else begin
                        rsp_err      <= 1'b1;
                        rsp_quantity <= '0;
                        rsp_vld      <= 1'b1;
                        state        <= RSP;
                    end
                end
                BUSY: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (!cnt_busy) begin
                        rsp_quantity <= cnt_rsp_quantity;
                        rsp_err      <= 1'b0;
                        rsp_vld      <= 1'b1;
                        state        <= RSP;
                    end else if (wd_cnt == WD_W'(TIMEOUT_N - 1)) begin
                        rsp_quantity <= '0;
                        rsp_err      <= 1'b1;
                        rsp_vld      <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ob_mk_cnt_sched.sv
// Randomized scoreboard bench for ob_mk_cnt_sched. A behavioural engine model
// answers each command; expected responses come from a round-robin reference
// model and are checked by an independent response monitor.
module tb_ob_mk_cnt_sched;

    localparam int REQ_N     = 2;
    localparam int ACC_W     = 32;
    localparam int TIMEOUT_N = 64;
    localparam int ID_W      = $clog2(REQ_N);

    localparam int K_NORM   = 0;
    localparam int K_REFUSE = 1;
    localparam int K_STALL  = 2;

    typedef struct {
        int             id;
        int             kind;
        int             mux;
        logic [ACC_W-1:0] qty;
    } eng_t;

    typedef struct {
        int             id;
        logic [ACC_W-1:0] qty;
        logic           err;
        int             lat;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [REQ_N-1:0]   req_vld;
    logic [REQ_N-1:0]   req_rdy;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [ID_W-1:0]    rsp_id;
    logic [ACC_W-1:0]   rsp_quantity;
    logic               rsp_err;
    logic               cnt_cmd_vld;
    logic [ID_W-1:0]    cnt_tbl_sel;
    logic               cnt_busy;
    logic [ACC_W-1:0]   cnt_rsp_quantity;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t exp_q[$];
    eng_t eng_q[$];
    int   acc_q[$];

    int               model_ptr   = REQ_N - 1;
    logic [REQ_N-1:0] held        = '0;
    int               last_hs_cyc = -100;
    logic             pend_refuse = 1'b0;
    int               eng_left    = 0;
    int               eng_load    = -1;
    int               cur_id      = 0;
    int               cur_kind    = K_NORM;
    int               bp_left     = 0;

    ob_mk_cnt_sched #(
        .REQ_N     (REQ_N),
        .ACC_W     (ACC_W),
        .TIMEOUT_N (TIMEOUT_N)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_vld          (req_vld),
        .req_rdy          (req_rdy),
        .rsp_vld          (rsp_vld),
        .rsp_rdy          (rsp_rdy),
        .rsp_id           (rsp_id),
        .rsp_quantity     (rsp_quantity),
        .rsp_err          (rsp_err),
        .cnt_cmd_vld      (cnt_cmd_vld),
        .cnt_tbl_sel      (cnt_tbl_sel),
        .cnt_busy         (cnt_busy),
        .cnt_rsp_quantity (cnt_rsp_quantity)
    );

    // Free-running clock and cycle index.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arbitration: first requester after the previous winner, wrapping.
    function automatic int predictGrant(input logic [REQ_N-1:0] pat);
        for (int k = 1; k <= REQ_N; k++) begin
            if (pat[(model_ptr + k) % REQ_N]) return (model_ptr + k) % REQ_N;
        end
        return -1;
    endfunction

    // Engine busy: answers the command directly, then counts down its rounds.
    assign cnt_busy = cnt_cmd_vld ? !pend_refuse : (eng_left > 0);

    // Engine model: consume one behaviour record per command strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cnt_cmd_vld) begin
                if (eng_q.size() == 0) begin
                    checkOutput("cmd_expected", 64'(eng_q.size()), 64'd1);
                end else begin
                    eng_t g;
                    g = eng_q.pop_front();
                    checkOutput("tbl_sel_at_cmd", 64'(cnt_tbl_sel), 64'(g.id));
                    cnt_rsp_quantity = g.qty;
                    cur_id   = g.id;
                    cur_kind = g.kind;
                    if (g.kind == K_NORM)       eng_load = g.mux + 1;
                    else if (g.kind == K_STALL) eng_load = TIMEOUT_N + 2;
                    else                        eng_load = 0;
                end
            end else if (eng_left > 0 && cur_kind == K_NORM) begin
                checkOutput("tbl_sel_hold", 64'(cnt_tbl_sel), 64'(cur_id));
            end
        end
    end

    // Engine model round counter, updated just after the edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            eng_left = 0;
            eng_load = -1;
        end else if (eng_load >= 0) begin
            eng_left = eng_load;
            eng_load = -1;
        end else if (eng_left > 0) begin
            eng_left--;
        end
    end

    // Response consumer with random stalls and occasional 10-cycle backpressure.
    initial rsp_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bp_left > 0) begin
            rsp_rdy = 1'b0;
            bp_left--;
        end else if ($urandom_range(0, 9) == 0) begin
            rsp_rdy = 1'b0;
            bp_left = 10;
        end else begin
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: latency, stability under backpressure, and scoreboard compare.
    logic                  prev_vld = 1'b0;
    logic [ID_W+ACC_W:0]   hold_v;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else if (rsp_vld) begin
            checkOutput("quiet_in_rsp", 64'({req_rdy, cnt_cmd_vld}), 64'd0);
            if (!prev_vld) begin
                if (acc_q.size() == 0 || exp_q.size() == 0) begin
                    checkOutput("rsp_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    checkOutput("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(exp_q[0].lat));
                end
                hold_v = {rsp_id, rsp_quantity, rsp_err};
            end else begin
                checkOutput("rsp_hold", 64'({rsp_id, rsp_quantity, rsp_err}), 64'(hold_v));
            end
            if (rsp_rdy) begin
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                    checkOutput("rsp_quantity", 64'(rsp_quantity), 64'(e.qty));
                    checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                last_hs_cyc = cyc;
                prev_vld = 1'b0;
            end else begin
                prev_vld = 1'b1;
            end
        end else begin
            prev_vld = 1'b0;
        end
    end

    // One transaction: raise a request pattern, check the grant, hand the engine its behaviour.
    task automatic applyStimulus(input logic [REQ_N-1:0] add_bits, input int kind, input int mux,
                                 input logic [ACC_W-1:0] qty, output bit ok);
        logic [REQ_N-1:0] pat;
        logic [REQ_N-1:0] oh;
        int   gid;
        int   raise_cyc;
        int   want_acc;
        bit   got;
        exp_t e;
        eng_t g;
        pat = held | add_bits;
        if (pat == '0) pat = REQ_N'(1);
        gid = predictGrant(pat);
        oh = '0;
        oh[gid] = 1'b1;
        e.id  = gid;
        e.qty = (kind == K_NORM) ? qty : '0;
        e.err = (kind != K_NORM);
        e.lat = (kind == K_NORM) ? mux + 4 : (kind == K_REFUSE) ? 2 : TIMEOUT_N + 2;
        g.id   = gid;
        g.kind = kind;
        g.mux  = mux;
        g.qty  = qty;
        exp_q.push_back(e);
        eng_q.push_back(g);
        pend_refuse = (kind == K_REFUSE);
        @(posedge clk);
        #1;
        req_vld   = pat;
        raise_cyc = cyc;
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ((req_vld & req_rdy) != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checkOutput("accept_wait", 64'(got), 64'd1);
            ok = 1'b0;
            return;
        end
        want_acc = (raise_cyc > last_hs_cyc + 1) ? raise_cyc : last_hs_cyc + 1;
        checkOutput("grant", 64'(req_rdy), 64'(oh));
        checkOutput("accept_cycle", 64'(cyc), 64'(want_acc));
        acc_q.push_back(cyc);
        model_ptr = gid;
        held = pat & ~oh;
        @(posedge clk);
        #1;
        req_vld = held;
        @(posedge clk);
        #1;
        ok = 1'b1;
    endtask

    // Wait, bounded, for every expected response to be consumed.
    task automatic drainResponses();
        for (int n = 0; n < 600 && exp_q.size() != 0; n++) @(negedge clk);
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Hard stop in case something upstream wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: actual time limit reached, required $finish first");
        $fatal(1, "[TB] global timeout");
    end

    // Main sequence: reset, directed cases, random traffic, async reset.
    initial begin
        bit ok;
        int kind;
        int r;
        ok = 1'b1;
        rst_n = 1'b0;
        req_vld = '0;
        cnt_rsp_quantity = '0;
        #3;
        checkOutput("reset_values", 64'({req_rdy, rsp_vld, rsp_id, rsp_quantity, rsp_err, cnt_cmd_vld, cnt_tbl_sel}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(2'b01, K_NORM, 3, 32'h1234, ok);
        for (int i = 0; i < 4 && ok; i++) applyStimulus(2'b11, K_NORM, $urandom_range(1, 4), $urandom, ok);
        if (ok) applyStimulus(2'b01, K_REFUSE, 1, $urandom, ok);
        if (ok) applyStimulus(2'b10, K_STALL, 1, $urandom, ok);
        if (ok) applyStimulus(2'b01, K_NORM, 2, $urandom, ok);

        for (int i = 0; i < 40 && ok; i++) begin
            r = $urandom_range(0, 19);
            kind = (r == 0) ? K_STALL : (r < 3) ? K_REFUSE : K_NORM;
            if (held == '0) repeat ($urandom_range(0, 4)) @(posedge clk);
            applyStimulus(REQ_N'($urandom_range(0, 3)), kind, $urandom_range(1, 5), $urandom, ok);
        end
        for (int i = 0; i < REQ_N && held != '0 && ok; i++) applyStimulus('0, K_NORM, 2, $urandom, ok);
        drainResponses();

        if (ok) begin
            applyStimulus(2'b10, K_NORM, 5, $urandom, ok);
            #3;
            rst_n = 1'b0;
            #1;
            checkOutput("async_reset", 64'({req_rdy, rsp_vld, rsp_id, rsp_quantity, rsp_err, cnt_cmd_vld, cnt_tbl_sel}), 64'd0);
            req_vld = '0;
            held = '0;
            exp_q.delete();
            acc_q.delete();
            eng_q.delete();
            model_ptr = REQ_N - 1;
            last_hs_cyc = -100;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            if (ok) applyStimulus(2'b10, K_NORM, 3, $urandom, ok);
            drainResponses();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
